detect_58_seq: RTL and testbench
================================

Name: detect_58_seq

Overview:
- Serial pattern detector, clocked.
- Owns the 4-bit state register and registered match output.
- Detects the 8-bit pattern 0x58 (bit order 0,1,0,1,1,0,0,0, MSB first) on a serial bit stream. Overlapping occurrences count.
- Sits between the upstream serial bit source (bit + valid) and the downstream match consumer. The 9-state transition function (states 0..8) is implemented inside this block.

Parameters:
- none (pattern and state encoding fixed).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of state and match (and counter if enabled)
- in_valid  input  1  in_bit is accepted on this rising edge
- in_bit  input  1  serial data bit
- state  output  4  current state, 0..8 = number of pattern bits matched
- match  output  1  one-cycle pulse, high the cycle after the 8th pattern bit is accepted
- match_count  output  8  saturating match count (only with DETECT_58_COUNT_EN)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous): state=0, match=0, match_count=0. All three are held while rst_n is low. Normal operation resumes from the first rising edge after deassertion.
- Priority on each rising edge: clr, then in_valid.
  - clr=1: state<=0, match<=0, match_count<=0. in_bit is ignored even if in_valid=1.
- in_valid=0: state holds, match<=0.
- in_valid=1: state<=next(state,in_bit). match<=1 if next==8, else 0.
- Transition table, written as state: next on in=0 / next on in=1:
  - 0: 1 / 0
  - 1: 1 / 2
  - 2: 3 / 0
  - 3: 1 / 4
  - 4: 3 / 5
  - 5: 6 / 0
  - 6: 7 / 2
  - 7: 8 / 2
  - 8: 1 / 2
- Overlap: state 8 behaves exactly as state 1 (the border of the pattern is "0").
- Illegal states 9..15 are unreachable. If entered, the next edge forces state<=0 regardless of in_valid, and match<=0.
- Latency: match rises on the same edge that accepts the final 0. It is visible for exactly one cycle.
- Back-to-back: match can reassert no sooner than 7 accepted bits later. Minimum spacing is 7 bits, via the overlap from state 8.
- Gaps (in_valid=0) anywhere in the sequence are transparent. A match still fires when the pattern bits arrive non-contiguously in time.
- state is a direct register output; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DETECT_58_COUNT_EN.
- Defined:
  - 8-bit match_count increments by 1 on every edge where match is set. It saturates at 255.
  - Cleared by rst_n and clr.
  - Count is updated in the same edge as match, so it is visible together with the match pulse.
- Undefined:
  - match_count port is still present and tied to 8'd0.
  - No counter flops are synthesized.

Test Plan:
- Reset then stream 0,1,0,1,1,0,0,0 with in_valid=1 every cycle -> state steps 1,2,3,4,5,6,7,8; match=1 only in the cycle after the 8th bit; match_count=1 (with macro).
- Stream 0,1,0,1,1,0,0,0,1,0,1,1,0,0,0 -> state goes 8 then 2 on the 9th bit; second match 7 bits later; match_count=2.
- Same 8 bits with in_valid low for 3 cycles between bits 4 and 5 -> state holds at 4 during the gap; single match at end.
- Near-miss 0,1,0,1,0,1,1,0,0,0 -> state 4 then 3 on the 5th bit; match fires after the 10th bit only.
- Pulse rst_n low asynchronously while state=6 (mid-clock) -> state=0 and match=0 immediately, without waiting for an edge.
- clr=1 with in_valid=1 at state=7, in_bit=0 -> state=0, no match, count cleared. With the macro: 300 consecutive matches -> match_count=255.

Source files
------------

// File: rtl/detect_58_seq.sv
// Serial detector for the 8-bit pattern 0x58 (0,1,0,1,1,0,0,0 MSB first), overlapping matches.
// Optional saturating match counter enabled by defining DETECT_58_COUNT_EN.
module detect_58_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic [3:0] state,
    output logic       match,
    output logic [7:0] match_count
);

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;

    state_t r_state;
    logic   r_match;
    state_t w_next;
    logic   w_legal;
    logic   w_hit;

    // State n = number of leading pattern bits currently matched; S8 overlaps like S1.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = in_bit ? S0 : S1;
            S1:      w_next = in_bit ? S2 : S1;
            S2:      w_next = in_bit ? S0 : S3;
            S3:      w_next = in_bit ? S4 : S1;
            S4:      w_next = in_bit ? S5 : S3;
            S5:      w_next = in_bit ? S0 : S6;
            S6:      w_next = in_bit ? S2 : S7;
            S7:      w_next = in_bit ? S2 : S8;
            S8:      w_next = in_bit ? S2 : S1;
            default: w_next = S0;
        endcase
    end

    assign w_legal = (r_state <= S8);
    assign w_hit   = in_valid && w_legal && (w_next == S8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
            r_match <= 1'b0;
        end else if (clr) begin
            r_state <= S0;
            r_match <= 1'b0;
        end else if (!w_legal) begin
            r_state <= S0;
            r_match <= 1'b0;
        end else if (in_valid) begin
            r_state <= w_next;
            r_match <= w_hit;
        end else begin
            r_match <= 1'b0;
        end
    end

    assign state = r_state;
    assign match = r_match;

`ifdef DETECT_58_COUNT_EN
    logic [7:0] r_count;

    // Counts on the same edge that raises match, so both appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clr) begin
            r_count <= 8'd0;
        end else if (w_hit && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign match_count = r_count;
`else
    assign match_count = 8'd0;
`endif

endmodule

// File: tb/tb_detect_58_seq.sv
// Directed self-checking bench for detect_58_seq using immediate assertions.
module tb_detect_58_seq;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_bit;
    logic [3:0] state;
    logic       match;
    logic [7:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    detect_58_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .state       (state),
        .match       (match),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt_exp();
`ifdef DETECT_58_COUNT_EN
        return 8'(exp_cnt);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check_all(input string tag, input logic [3:0] exp_state, input logic exp_match);
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".match"}, 32'(match), 32'(exp_match));
        chk({tag, ".count"}, 32'(match_count), 32'(cnt_exp()));
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic b, input logic [3:0] exp_state,
                        input logic exp_match, input string tag);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        if (exp_match && exp_cnt < 255) exp_cnt++;
        check_all(tag, exp_state, exp_match);
        $display("step %s v=%0d b=%0d state=%0d match=%0d count=%0d", tag, v, b, state, match, match_count);
    endtask

    task automatic do_clr(input logic v, input logic b, input string tag);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        check_all(tag, 4'd0, 1'b0);
        $display("clear %s state=%0d match=%0d count=%0d", tag, state, match, match_count);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean pattern
        step(1, 0, 4'd1, 0, "p1_0");
        step(1, 1, 4'd2, 0, "p1_1");
        step(1, 0, 4'd3, 0, "p1_2");
        step(1, 1, 4'd4, 0, "p1_3");
        step(1, 1, 4'd5, 0, "p1_4");
        step(1, 0, 4'd6, 0, "p1_5");
        step(1, 0, 4'd7, 0, "p1_6");
        step(1, 0, 4'd8, 1, "p1_7");
        step(0, 1, 4'd8, 0, "idle_hold");

        // Overlapped second match, 7 bits after the first
        step(1, 1, 4'd2, 0, "ov_0");
        step(1, 0, 4'd3, 0, "ov_1");
        step(1, 1, 4'd4, 0, "ov_2");
        step(1, 1, 4'd5, 0, "ov_3");
        step(1, 0, 4'd6, 0, "ov_4");
        step(1, 0, 4'd7, 0, "ov_5");
        step(1, 0, 4'd8, 1, "ov_6");
        step(1, 1, 4'd2, 0, "ov_after");

        // Gap of three idle cycles between bits 4 and 5
        do_clr(0, 0, "clr_gap");
        step(1, 0, 4'd1, 0, "gap_0");
        step(1, 1, 4'd2, 0, "gap_1");
        step(1, 0, 4'd3, 0, "gap_2");
        step(1, 1, 4'd4, 0, "gap_3");
        step(0, 0, 4'd4, 0, "gap_idle0");
        step(0, 1, 4'd4, 0, "gap_idle1");
        step(0, 0, 4'd4, 0, "gap_idle2");
        step(1, 1, 4'd5, 0, "gap_4");
        step(1, 0, 4'd6, 0, "gap_5");
        step(1, 0, 4'd7, 0, "gap_6");
        step(1, 0, 4'd8, 1, "gap_7");

        // Near miss 0,1,0,1,0,1,1,0,0,0
        do_clr(0, 0, "clr_nm");
        step(1, 0, 4'd1, 0, "nm_0");
        step(1, 1, 4'd2, 0, "nm_1");
        step(1, 0, 4'd3, 0, "nm_2");
        step(1, 1, 4'd4, 0, "nm_3");
        step(1, 0, 4'd3, 0, "nm_4");
        step(1, 1, 4'd4, 0, "nm_5");
        step(1, 1, 4'd5, 0, "nm_6");
        step(1, 0, 4'd6, 0, "nm_7");
        step(1, 0, 4'd7, 0, "nm_8");
        step(1, 0, 4'd8, 1, "nm_9");
        step(1, 1, 4'd2, 0, "nm_after");

        // Asynchronous reset mid-cycle at state 6
        step(1, 0, 4'd3, 0, "ar_0");
        step(1, 1, 4'd4, 0, "ar_1");
        step(1, 1, 4'd5, 0, "ar_2");
        step(1, 0, 4'd6, 0, "ar_3");
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_all("async_rst_now", 4'd0, 1'b0);
        $display("async reset asserted state=%0d match=%0d count=%0d", state, match, match_count);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk);
        #1;
        check_all("async_rst_held", 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear beats a valid final bit at state 7
        step(1, 0, 4'd1, 0, "cl_0");
        step(1, 1, 4'd2, 0, "cl_1");
        step(1, 0, 4'd3, 0, "cl_2");
        step(1, 1, 4'd4, 0, "cl_3");
        step(1, 1, 4'd5, 0, "cl_4");
        step(1, 0, 4'd6, 0, "cl_5");
        step(1, 0, 4'd7, 0, "cl_6");
        do_clr(1, 0, "clr_at7");
        step(1, 0, 4'd1, 0, "cl_after");

        // 300 consecutive matches for counter saturation
        do_clr(0, 0, "clr_sat");
        step(1, 0, 4'd1, 0, "sat_h0");
        step(1, 1, 4'd2, 0, "sat_h1");
        step(1, 0, 4'd3, 0, "sat_h2");
        step(1, 1, 4'd4, 0, "sat_h3");
        step(1, 1, 4'd5, 0, "sat_h4");
        step(1, 0, 4'd6, 0, "sat_h5");
        step(1, 0, 4'd7, 0, "sat_h6");
        step(1, 0, 4'd8, 1, "sat_h7");
        for (int k = 0; k < 299; k++) begin
            step(1, 1, 4'd2, 0, "sat_1");
            step(1, 0, 4'd3, 0, "sat_2");
            step(1, 1, 4'd4, 0, "sat_3");
            step(1, 1, 4'd5, 0, "sat_4");
            step(1, 0, 4'd6, 0, "sat_5");
            step(1, 0, 4'd7, 0, "sat_6");
            step(1, 0, 4'd8, 1, "sat_7");
        end
`ifdef DETECT_58_COUNT_EN
        chk("sat_final", 32'(match_count), 32'd255);
`else
        chk("sat_final", 32'(match_count), 32'd0);
`endif
        do_clr(0, 0, "clr_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
